// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - Decode/Execute pipeline register with forwarding muxes and scalar/vector ALUs
module execute_stage (
    input  logic          clk,
    input  logic          reset,
    input  logic [19:0]   ctrl_in,
    input  logic [15:0]   srcA_in,
    input  logic [15:0]   srcB_in,
    input  logic [127:0]  vsrcA_in,
    input  logic [127:0]  vsrcB_in,
    input  logic [4:0]    rs1_decode,
    input  logic [4:0]    rs2_decode,
    input  logic [4:0]    rd_decode,
    input  logic [2:0]    fwd_sel_a,
    input  logic [2:0]    fwd_sel_b,
    input  logic [15:0]   wb_data,
    input  logic [7:0]    mem_result,
    input  logic [127:0]  wb_vector,
    input  logic [127:0]  mem_vresult,
    output logic          wre_execute,
    output logic          vector_wre_execute,
    output logic          wme_a_execute,
    output logic          wme_b_execute,
    output logic          load_instruction,
    output logic [1:0]    sel_wb_execute,
    output logic [1:0]    sel_wb_vec_execute,
    output logic [4:0]    alu_op,
    output logic [4:0]    valu_op,
    output logic [15:0]   srcA_execute,
    output logic [15:0]   srcB_execute,
    output logic [127:0]  vsrcA_execute,
    output logic [127:0]  vsrcB_execute,
    output logic [4:0]    rs1_execute,
    output logic [4:0]    rs2_execute,
    output logic [4:0]    rd_execute,
    output logic [15:0]   alu_src_b,
    output logic [7:0]    alu_result,
    output logic [127:0]  valu_result
);

    // Bit 0 of the control word is reserved and intentionally dropped.
    logic ctrl_unused;
    assign ctrl_unused = ctrl_in[0];

    logic [7:0]   fwd_a;
    logic [15:0]  fwd_b;
    logic [127:0] vfwd_a;
    logic [127:0] vfwd_b;

    function automatic logic [7:0] alu8(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        case (op)
            5'd0:    r = a + b;
            5'd1:    r = a - b;
            5'd2:    r = a & b;
            5'd3:    r = a | b;
            5'd4:    r = a ^ b;
            5'd5:    r = a << b[2:0];
            5'd6:    r = a >> b[2:0];
            5'd7:    r = a * b;
            5'd8:    r = a;
            5'd9:    r = b;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wre_execute        <= 1'b0;
            vector_wre_execute <= 1'b0;
            wme_a_execute      <= 1'b0;
            wme_b_execute      <= 1'b0;
            sel_wb_execute     <= 2'd0;
            sel_wb_vec_execute <= 2'd0;
            alu_op             <= 5'd0;
            valu_op            <= 5'd0;
            load_instruction   <= 1'b0;
            srcA_execute       <= 16'd0;
            srcB_execute       <= 16'd0;
            vsrcA_execute      <= 128'd0;
            vsrcB_execute      <= 128'd0;
            rs1_execute        <= 5'd0;
            rs2_execute        <= 5'd0;
            rd_execute         <= 5'd0;
        end else begin
            wre_execute        <= ctrl_in[19];
            vector_wre_execute <= ctrl_in[18];
            wme_a_execute      <= ctrl_in[17];
            wme_b_execute      <= ctrl_in[16];
            sel_wb_execute     <= ctrl_in[15:14];
            sel_wb_vec_execute <= ctrl_in[13:12];
            alu_op             <= ctrl_in[11:7];
            valu_op            <= ctrl_in[6:2];
            load_instruction   <= ctrl_in[1];
            srcA_execute       <= srcA_in;
            srcB_execute       <= srcB_in;
            vsrcA_execute      <= vsrcA_in;
            vsrcB_execute      <= vsrcB_in;
            rs1_execute        <= rs1_decode;
            rs2_execute        <= rs2_decode;
            rd_execute         <= rd_decode;
        end
    end

    // Selects 3..7 are unassigned encodings and fall back to the captured operand.
    always_comb begin
        case (fwd_sel_a)
            3'd1:    fwd_a = wb_data[7:0];
            3'd2:    fwd_a = mem_result;
            default: fwd_a = srcA_execute[7:0];
        endcase
        case (fwd_sel_b)
            3'd1:    fwd_b = wb_data;
            3'd2:    fwd_b = {8'h00, mem_result};
            default: fwd_b = srcB_execute;
        endcase
        case (fwd_sel_a)
            3'd1:    vfwd_a = wb_vector;
            3'd2:    vfwd_a = mem_vresult;
            default: vfwd_a = vsrcA_execute;
        endcase
        case (fwd_sel_b)
            3'd1:    vfwd_b = wb_vector;
            3'd2:    vfwd_b = mem_vresult;
            default: vfwd_b = vsrcB_execute;
        endcase
    end

    assign alu_src_b  = fwd_b;
    assign alu_result = alu8(alu_op, fwd_a, fwd_b[7:0]);

    always_comb begin
        valu_result = '0;
        for (int i = 0; i < 16; i++) begin
            valu_result[8*i +: 8] = alu8(valu_op, vfwd_a[8*i +: 8], vfwd_b[8*i +: 8]);
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - self-checking bench for execute_stage against a behavioural model
module tb_execute_stage;

    logic          clk;
    logic          rst_n;
    logic [19:0]   ctrl_in;
    logic [15:0]   srcA_in, srcB_in;
    logic [127:0]  vsrcA_in, vsrcB_in;
    logic [4:0]    rs1_decode, rs2_decode, rd_decode;
    logic [2:0]    fwd_sel_a, fwd_sel_b;
    logic [15:0]   wb_data;
    logic [7:0]    mem_result;
    logic [127:0]  wb_vector, mem_vresult;
    logic          wre_execute, vector_wre_execute, wme_a_execute, wme_b_execute, load_instruction;
    logic [1:0]    sel_wb_execute, sel_wb_vec_execute;
    logic [4:0]    alu_op, valu_op;
    logic [15:0]   srcA_execute, srcB_execute;
    logic [127:0]  vsrcA_execute, vsrcB_execute;
    logic [4:0]    rs1_execute, rs2_execute, rd_execute;
    logic [15:0]   alu_src_b;
    logic [7:0]    alu_result;
    logic [127:0]  valu_result;

    int checks = 0;
    int failures = 0;

    execute_stage dut (
        .clk(clk), .reset(rst_n), .ctrl_in(ctrl_in),
        .srcA_in(srcA_in), .srcB_in(srcB_in), .vsrcA_in(vsrcA_in), .vsrcB_in(vsrcB_in),
        .rs1_decode(rs1_decode), .rs2_decode(rs2_decode), .rd_decode(rd_decode),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .wb_data(wb_data), .mem_result(mem_result), .wb_vector(wb_vector), .mem_vresult(mem_vresult),
        .wre_execute(wre_execute), .vector_wre_execute(vector_wre_execute),
        .wme_a_execute(wme_a_execute), .wme_b_execute(wme_b_execute),
        .load_instruction(load_instruction),
        .sel_wb_execute(sel_wb_execute), .sel_wb_vec_execute(sel_wb_vec_execute),
        .alu_op(alu_op), .valu_op(valu_op),
        .srcA_execute(srcA_execute), .srcB_execute(srcB_execute),
        .vsrcA_execute(vsrcA_execute), .vsrcB_execute(vsrcB_execute),
        .rs1_execute(rs1_execute), .rs2_execute(rs2_execute), .rd_execute(rd_execute),
        .alu_src_b(alu_src_b), .alu_result(alu_result), .valu_result(valu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [18:0]  ctrl_out = {wre_execute, vector_wre_execute, wme_a_execute, wme_b_execute,
                             sel_wb_execute, sel_wb_vec_execute, alu_op, valu_op, load_instruction};
    wire [321:0] all_regs = {ctrl_out, srcA_execute, srcB_execute, vsrcA_execute, vsrcB_execute,
                             rs1_execute, rs2_execute, rd_execute};

    task automatic chk(input string name, input logic [329:0] got, input logic [329:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference ALU written as plain integer arithmetic on one 8-bit lane.
    function automatic logic [7:0] m_alu(input int op, input int a, input int b);
        int r;
        case (op)
            0:       r = (a + b) % 256;
            1:       r = (a - b + 256) % 256;
            2:       r = a & b;
            3:       r = a | b;
            4:       r = a ^ b;
            5:       r = (a * (2 ** (b % 8))) % 256;
            6:       r = a / (2 ** (b % 8));
            7:       r = (a * b) % 256;
            8:       r = a;
            9:       r = b;
            default: r = 0;
        endcase
        return r[7:0];
    endfunction

    function automatic logic [19:0] mk_ctrl(input int alu, input int valu);
        int v;
        v = ((alu % 32) * 128) + ((valu % 32) * 4);
        return v[19:0];
    endfunction

    // Model of the captured instruction: whatever Decode presented at the last edge.
    logic [19:0]  m_ctrl = '0;
    logic [15:0]  m_a = '0, m_b = '0;
    logic [127:0] m_va = '0, m_vb = '0;
    logic [4:0]   m_rs1 = '0, m_rs2 = '0, m_rd = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ctrl = '0; m_a = '0; m_b = '0; m_va = '0; m_vb = '0;
            m_rs1 = '0; m_rs2 = '0; m_rd = '0;
        end else begin
            m_ctrl = ctrl_in; m_a = srcA_in; m_b = srcB_in; m_va = vsrcA_in; m_vb = vsrcB_in;
            m_rs1 = rs1_decode; m_rs2 = rs2_decode; m_rd = rd_decode;
        end
    end

    always @(negedge clk) begin
        logic [15:0]  fa, fb;
        logic [127:0] vfa, vfb, vexp;
        fa  = (fwd_sel_a == 1) ? wb_data   : (fwd_sel_a == 2) ? {8'h00, mem_result} : m_a;
        fb  = (fwd_sel_b == 1) ? wb_data   : (fwd_sel_b == 2) ? {8'h00, mem_result} : m_b;
        vfa = (fwd_sel_a == 1) ? wb_vector : (fwd_sel_a == 2) ? mem_vresult : m_va;
        vfb = (fwd_sel_b == 1) ? wb_vector : (fwd_sel_b == 2) ? mem_vresult : m_vb;
        for (int i = 0; i < 16; i++)
            vexp[8*i +: 8] = m_alu(int'(m_ctrl[6:2]), int'(vfa[8*i +: 8]), int'(vfb[8*i +: 8]));
        chk("m_ctrl_fields", 330'(ctrl_out), 330'(m_ctrl[19:1]));
        chk("m_scalar_ops", 330'({srcA_execute, srcB_execute}), 330'({m_a, m_b}));
        chk("m_vector_ops", 330'({vsrcA_execute, vsrcB_execute}), 330'({m_va, m_vb}));
        chk("m_indices", 330'({rs1_execute, rs2_execute, rd_execute}), 330'({m_rs1, m_rs2, m_rd}));
        chk("m_alu_src_b", 330'(alu_src_b), 330'(fb));
        chk("m_alu_result", 330'(alu_result), 330'(m_alu(int'(m_ctrl[11:7]), int'(fa[7:0]), int'(fb[7:0]))));
        chk("m_valu_result", 330'(valu_result), 330'(vexp));
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        logic [31:0] c;
        c = $urandom;
        c[11:7] = 5'($urandom_range(0, 11));
        c[6:2]  = 5'($urandom_range(0, 11));
        ctrl_in     = c[19:0];
        srcA_in     = 16'($urandom);
        srcB_in     = 16'($urandom);
        vsrcA_in    = {$urandom, $urandom, $urandom, $urandom};
        vsrcB_in    = {$urandom, $urandom, $urandom, $urandom};
        rs1_decode  = 5'($urandom);
        rs2_decode  = 5'($urandom);
        rd_decode   = 5'($urandom);
        fwd_sel_a   = 3'($urandom_range(0, 7));
        fwd_sel_b   = 3'($urandom_range(0, 7));
        wb_data     = 16'($urandom);
        mem_result  = 8'($urandom);
        wb_vector   = {$urandom, $urandom, $urandom, $urandom};
        mem_vresult = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        rst_n = 1'b0;
        rand_inputs();
        ctrl_in   = 20'hFFFFE;
        fwd_sel_a = 3'd0;
        fwd_sel_b = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("reset_regs", 330'(all_regs), 330'd0);
        chk("reset_alu", 330'(alu_result), 330'd0);
        chk("reset_valu", 330'(valu_result), 330'd0);

        rst_n = 1'b1;
        step();
        chk("ctrl_all_ones", 330'(ctrl_out), 330'(19'h7FFFF));
        ctrl_in = 20'h0;
        step();
        chk("ctrl_bubble", 330'(ctrl_out), 330'd0);

        ctrl_in = mk_ctrl(0, 0); srcA_in = 16'h00F0; srcB_in = 16'h0020;
        step();
        chk("add_f0_20", 330'(alu_result), 330'(8'h10));
        ctrl_in = mk_ctrl(1, 0); srcA_in = 16'h0005; srcB_in = 16'h0007;
        step();
        chk("sub_05_07", 330'(alu_result), 330'(8'hFE));
        ctrl_in = mk_ctrl(7, 0); srcA_in = 16'h0010; srcB_in = 16'h0011;
        step();
        chk("mul_10_11", 330'(alu_result), 330'(8'h10));

        ctrl_in = mk_ctrl(0, 0); srcA_in = 16'h0001; srcB_in = 16'h0001;
        step();
        fwd_sel_a = 3'd2; mem_result = 8'h7F; #1;
        chk("fwd_a_mem", 330'(alu_result), 330'(8'h80));
        fwd_sel_a = 3'd0; fwd_sel_b = 3'd1; wb_data = 16'h1234; #1;
        chk("fwd_b_wb", 330'(alu_src_b), 330'(16'h1234));
        fwd_sel_a = 3'd5; fwd_sel_b = 3'd0; #1;
        chk("fwd_a_sel5", 330'(alu_result), 330'(8'h02));

        ctrl_in = mk_ctrl(0, 0); vsrcA_in = {16{8'hFF}}; vsrcB_in = {16{8'h02}};
        step();
        chk("vadd_no_carry", 330'(valu_result), 330'({16{8'h01}}));
        ctrl_in = mk_ctrl(0, 5); vsrcA_in = 128'h01; vsrcB_in = 128'h03;
        step();
        chk("vsll_lane0", 330'(valu_result[7:0]), 330'(8'h08));

        ctrl_in = 20'h80000;
        step();
        chk("wre_set", 330'(wre_execute), 330'(1'b1));
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        chk("async_reset_wre", 330'(wre_execute), 330'(1'b0));
        chk("async_reset_regs", 330'(all_regs), 330'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;

        for (int n = 0; n < 400; n++) begin
            rand_inputs();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
